// File: rtl/emissor_pedidos_if.sv
// Floor-request bus between the user panel, the request emitter and the elevator manager.
interface emissor_pedidos_if #(
    parameter int DEPTH = 4
);
    logic                     pedido;
    logic [3:0]               pedido_origem;
    logic [3:0]               pedido_destino;
    logic [3:0]               origem;
    logic [3:0]               destino;
    logic                     novaEntrada;
    logic                     ocupado;
    logic                     fila_vazia;
    logic                     fila_cheia;
    logic [$clog2(DEPTH):0]   nivel;
    logic                     descartado;

    modport master (
        output pedido, pedido_origem, pedido_destino,
        input  origem, destino, novaEntrada, ocupado,
        input  fila_vazia, fila_cheia, nivel, descartado
    );

    modport slave (
        input  pedido, pedido_origem, pedido_destino,
        output origem, destino, novaEntrada, ocupado,
        output fila_vazia, fila_cheia, nivel, descartado
    );
endinterface

// File: rtl/emissor_pedidos.sv
// Queues floor requests and replays each as prepare/pulse/gap toward the manager; first pulse 3 cycles after accept.
// No backpressure: overflow, invalid or duplicate (EMISSOR_FILTRO_DUPLICADO_EN) requests are dropped and flagged on descartado.
module emissor_pedidos #(
    parameter int DEPTH     = 4,
    parameter int MAX_ANDAR = 15,
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 2000
) (
    input logic              clock,
    input logic              reset,
    emissor_pedidos_if.slave bus
);
    localparam int PW   = $clog2(DEPTH);
    localparam int MAXC = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {OCIOSO, PREPARA, PULSO, ESPERA} estado_t;

    estado_t       estado;
    logic [CW-1:0] cnt;
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;
    logic [3:0]    origem_q;
    logic [3:0]    destino_q;
    logic          nova_q;
    logic          ocupado_q;
    logic          desc_q;

    logic vazia;
    logic cheia;
    logic pop;
    logic valido;
    logic duplicado;
    logic push;

    assign vazia  = (count == '0);
    assign cheia  = (count == (PW+1)'(DEPTH));
    assign pop    = (estado == OCIOSO) && !vazia;
    assign valido = (bus.pedido_origem != bus.pedido_destino)
                 && ({1'b0, bus.pedido_origem}  <= 5'(MAX_ANDAR))
                 && ({1'b0, bus.pedido_destino} <= 5'(MAX_ANDAR));

`ifdef EMISSOR_FILTRO_DUPLICADO_EN
    logic [PW-1:0] off;

    // An entry is live when its distance from head is below the occupancy.
    always_comb begin
        off       = '0;
        duplicado = ocupado_q && (origem_q == bus.pedido_origem)
                              && (destino_q == bus.pedido_destino);
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - head;
            if (({1'b0, off} < count) && (mem[i] == {bus.pedido_origem, bus.pedido_destino}))
                duplicado = 1'b1;
        end
    end
`else
    assign duplicado = 1'b0;
`endif

    // A full FIFO still takes a request when the head leaves in the same cycle.
    assign push = bus.pedido && valido && !duplicado && (!cheia || pop);

    always_ff @(posedge clock) begin
        if (push)
            mem[tail] <= {bus.pedido_origem, bus.pedido_destino};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            desc_q <= 1'b0;
        end else begin
            desc_q <= bus.pedido && !push;
            if (push)
                tail <= tail + 1'b1;
            if (pop)
                head <= head + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado    <= OCIOSO;
            cnt       <= '0;
            origem_q  <= '0;
            destino_q <= '0;
            nova_q    <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (pop) begin
                        {origem_q, destino_q} <= mem[head];
                        ocupado_q             <= 1'b1;
                        estado                <= PREPARA;
                    end
                end
                PREPARA: begin
                    cnt    <= '0;
                    nova_q <= 1'b1;
                    estado <= PULSO;
                end
                PULSO: begin
                    if (cnt == CW'(PULSE_LEN - 1)) begin
                        cnt    <= '0;
                        nova_q <= 1'b0;
                        estado <= ESPERA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ESPERA: begin
                    if (cnt == CW'(GAP_LEN - 1)) begin
                        cnt       <= '0;
                        ocupado_q <= 1'b0;
                        estado    <= OCIOSO;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

    assign bus.origem      = origem_q;
    assign bus.destino     = destino_q;
    assign bus.novaEntrada = nova_q;
    assign bus.ocupado     = ocupado_q;
    assign bus.fila_vazia  = vazia;
    assign bus.fila_cheia  = cheia;
    assign bus.nivel       = count;
    assign bus.descartado  = desc_q;
endmodule

// File: tb/tb_emissor_pedidos.sv
// Directed bench for emissor_pedidos with DEPTH=4, MAX_ANDAR=9, PULSE_LEN=4, GAP_LEN=8.
module tb_emissor_pedidos;
    localparam int DEPTH = 4;

`ifdef EMISSOR_FILTRO_DUPLICADO_EN
    localparam bit FILTRO = 1'b1;
`else
    localparam bit FILTRO = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    emissor_pedidos_if #(.DEPTH(DEPTH)) bus ();

    emissor_pedidos #(
        .DEPTH(DEPTH), .MAX_ANDAR(9), .PULSE_LEN(4), .GAP_LEN(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] emitted[$];
    logic       prev_nova = 1'b0;

    // Record each (origem,destino) at the rising edge of novaEntrada.
    always @(negedge clock) begin
        if (bus.novaEntrada && !prev_nova)
            emitted.push_back({bus.origem, bus.destino});
        prev_nova = bus.novaEntrada;
    end

    typedef struct {
        logic [3:0] po;
        logic [3:0] pd;
        int         exp_desc;
        int         exp_nivel;
    } vec_t;

    vec_t tab[8];

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic p, input logic [3:0] o, input logic [3:0] d);
        bus.pedido         = p;
        bus.pedido_origem  = o;
        bus.pedido_destino = d;
    endtask

    task automatic do_reset();
        drive(1'b0, 4'd0, 4'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_free(input int budget, input string nm);
        int n = 0;
        while (bus.ocupado && n < budget) begin
            tick();
            n++;
        end
        chk({nm, "_timeout"}, int'(n < budget), 1);
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int n = 0;
        while ((bus.ocupado || !bus.fila_vazia) && n < budget) begin
            tick();
            n++;
        end
        chk({nm, "_timeout"}, int'(n < budget), 1);
    endtask

    task automatic chk_emitted(input string nm, input logic [7:0] exp[$]);
        chk({nm, "_count"}, emitted.size(), exp.size());
        for (int i = 0; i < exp.size() && i < emitted.size(); i++)
            chk($sformatf("%s_%0d", nm, i), emitted[i], exp[i]);
    endtask

    initial begin
        logic [7:0] exp_q[$];
        int         nv;
        int         exp_nivel5[5];

        tab[0] = '{4'd2,  4'd7,  0, 1};
        tab[1] = '{4'd3,  4'd3,  1, 0};
        tab[2] = '{4'd2,  4'd12, 1, 0};
        tab[3] = '{4'd10, 4'd1,  1, 0};
        tab[4] = '{4'd9,  4'd0,  0, 1};
        tab[5] = '{4'd0,  4'd9,  0, 1};
        tab[6] = '{4'd15, 4'd15, 1, 0};
        tab[7] = '{4'd4,  4'd10, 1, 0};
        exp_nivel5 = '{1, 1, 2, 3, 4};

        drive(1'b0, 4'd0, 4'd0);
        tick();
        do_reset();
        chk("rst_nivel",      bus.nivel,       0);
        chk("rst_fila_vazia", bus.fila_vazia,  1);
        chk("rst_fila_cheia", bus.fila_cheia,  0);
        chk("rst_nova",       bus.novaEntrada, 0);
        chk("rst_origem",     bus.origem,      0);
        chk("rst_destino",    bus.destino,     0);
        chk("rst_ocupado",    bus.ocupado,     0);
        chk("rst_descartado", bus.descartado,  0);

        // Single-request acceptance table, each from a fresh reset.
        for (int v = 0; v < 8; v++) begin
            do_reset();
            drive(1'b1, tab[v].po, tab[v].pd);
            tick();
            drive(1'b0, 4'd0, 4'd0);
            chk($sformatf("tab%0d_descartado", v), bus.descartado, tab[v].exp_desc);
            chk($sformatf("tab%0d_nivel", v),      bus.nivel,      tab[v].exp_nivel);
            chk($sformatf("tab%0d_vazia", v),      bus.fila_vazia, int'(tab[v].exp_nivel == 0));
            tick();
            chk($sformatf("tab%0d_desc_pulse", v), bus.descartado, 0);
            chk($sformatf("tab%0d_nivel_pop", v),  bus.nivel,      0);
        end

        // Latency and pulse/gap shape of one request.
        do_reset();
        drive(1'b1, 4'd2, 4'd7);
        tick();
        drive(1'b0, 4'd0, 4'd0);
        for (int c = 1; c <= 16; c++) begin
            chk($sformatf("lat_nova_c%0d", c),    bus.novaEntrada, int'(c >= 3 && c <= 6));
            chk($sformatf("lat_ocupado_c%0d", c), bus.ocupado,     int'(c >= 2 && c <= 14));
            chk($sformatf("lat_origem_c%0d", c),  bus.origem,      (c >= 2) ? 2 : 0);
            chk($sformatf("lat_destino_c%0d", c), bus.destino,     (c >= 2) ? 7 : 0);
            tick();
        end
        chk("lat_origem_hold", bus.origem, 2);

        // Five back-to-back, sixth rejected on full, then push during the pop cycle.
        do_reset();
        emitted.delete();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'(2 * i + 1), 4'((2 * i + 2) % 10));
            tick();
            chk($sformatf("b2b_desc_%0d", i),  bus.descartado, 0);
            chk($sformatf("b2b_nivel_%0d", i), bus.nivel,      exp_nivel5[i]);
        end
        drive(1'b1, 4'd2, 4'd4);
        tick();
        drive(1'b0, 4'd0, 4'd0);
        chk("full_descartado", bus.descartado, 1);
        chk("full_nivel",      bus.nivel,      4);
        chk("full_cheia",      bus.fila_cheia, 1);
        tick();
        chk("full_desc_pulse", bus.descartado, 0);
        wait_free(40, "full_free");
        chk("popcycle_nivel_before", bus.nivel, 4);
        drive(1'b1, 4'd6, 4'd7);
        tick();
        drive(1'b0, 4'd0, 4'd0);
        chk("popcycle_descartado", bus.descartado, 0);
        chk("popcycle_nivel",      bus.nivel,      4);
        wait_idle(200, "b2b_idle");
        exp_q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h90, 8'h67};
        chk_emitted("b2b_order", exp_q);

        // Invalid requests never reach the queue.
        do_reset();
        emitted.delete();
        drive(1'b1, 4'd3, 4'd3);
        tick();
        chk("inv_same_desc",  bus.descartado, 1);
        chk("inv_same_nivel", bus.nivel,      0);
        drive(1'b1, 4'd2, 4'd12);
        tick();
        drive(1'b0, 4'd0, 4'd0);
        chk("inv_range_desc",  bus.descartado, 1);
        chk("inv_range_nivel", bus.nivel,      0);
        repeat (30) tick();
        chk("inv_emitted", emitted.size(), 0);
        chk("inv_ocupado", bus.ocupado,    0);

        // Reset in the middle of a pulse drops everything.
        do_reset();
        drive(1'b1, 4'd1, 4'd2);
        tick();
        drive(1'b1, 4'd3, 4'd4);
        tick();
        drive(1'b0, 4'd0, 4'd0);
        nv = 0;
        while (!bus.novaEntrada && nv < 20) begin
            tick();
            nv++;
        end
        chk("mid_reach_pulso", int'(nv < 20), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_nova",    bus.novaEntrada, 0);
        chk("mid_origem",  bus.origem,      0);
        chk("mid_destino", bus.destino,     0);
        chk("mid_nivel",   bus.nivel,       0);
        chk("mid_ocupado", bus.ocupado,     0);
        emitted.delete();
        repeat (40) tick();
        chk("mid_emitted", emitted.size(), 0);

        // Duplicate pair while the first copy is still queued.
        do_reset();
        emitted.delete();
        drive(1'b1, 4'd2, 4'd3);
        tick();
        drive(1'b1, 4'd1, 4'd5);
        tick();
        drive(1'b1, 4'd1, 4'd5);
        tick();
        drive(1'b0, 4'd0, 4'd0);
        chk("dup_descartado", bus.descartado, int'(FILTRO));
        wait_idle(200, "dup_idle");
        if (FILTRO)
            exp_q = '{8'h23, 8'h15};
        else
            exp_q = '{8'h23, 8'h15, 8'h15};
        chk_emitted("dup_order", exp_q);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/emissor_pedidos.md
Name: emissor_pedidos

Overview:
- Request-side transmitter for the elevator manager datapath.
- Accepts floor-call strobes from the user panel and buffers them in a small FIFO.
- Replays each request on the manager's request interface: `origem`/`destino` held stable and `novaEntrada` raised for a fixed pulse, then a guard gap so the manager's edge detector and RAM insertion complete before the next request.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, 2..16.
- MAX_ANDAR, 15, highest valid floor number (4-bit).
- PULSE_LEN, 4, cycles `novaEntrada` is held high; >=1.
- GAP_LEN, 2000, cycles `novaEntrada` is held low after each pulse, outputs still stable; >=1.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- pedido  in  1  one-cycle strobe: new request on pedido_origem/pedido_destino.
- pedido_origem  in  4  requested origin floor.
- pedido_destino  in  4  requested destination floor.
- origem  out  4  origin floor presented to manager.
- destino  out  4  destination floor presented to manager.
- novaEntrada  out  1  request-valid level toward manager.
- ocupado  out  1  high whenever FSM is not OCIOSO.
- fila_vazia  out  1  FIFO count == 0.
- fila_cheia  out  1  FIFO count == DEPTH.
- nivel  out  clog2(DEPTH)+1  FIFO occupancy.
- descartado  out  1  one-cycle pulse, cycle after a rejected `pedido`.

Behaviour:
- Reset (one clock with reset=1):
  - FIFO emptied; `nivel`=0, `fila_vazia`=1, `fila_cheia`=0.
  - `origem`=0, `destino`=0, `novaEntrada`=0, `ocupado`=0, `descartado`=0, FSM=OCIOSO.
  - Reset mid-emission aborts immediately; the request in flight is lost.
- Acceptance, evaluated on a `pedido`=1 cycle:
  - Reject if origin==destination.
  - Reject if either value > MAX_ANDAR.
  - Reject if FIFO full and no pop in the same cycle.
  - Otherwise write at tail; `nivel` increments next cycle.
  - A rejected request leaves FIFO unchanged and pulses `descartado`=1 the following cycle.
- Simultaneous push+pop: allowed, including when full; `nivel` unchanged and order preserved.
- Pointers: head/tail wrap modulo DEPTH. `nivel` is a separate counter, never exceeds DEPTH, never underflows.
- FSM states and transitions:
  - OCIOSO: if FIFO not empty, pop head into `origem`/`destino` registers and go to PREPARA. `novaEntrada`=0.
  - PREPARA: one cycle, outputs stable, `novaEntrada`=0 (setup before rising edge). Go to PULSO, counter cleared.
  - PULSO: `novaEntrada`=1 for exactly PULSE_LEN cycles. Go to ESPERA, counter cleared.
  - ESPERA: `novaEntrada`=0 for exactly GAP_LEN cycles. `origem`/`destino` still held. Then go to OCIOSO.
- Outputs hold their last value in OCIOSO until the next pop; they are never zeroed except by reset.
- Latency, accept on an empty FIFO while OCIOSO:
  - cycle N: `pedido` sampled.
  - N+1: OCIOSO sees non-empty, pops.
  - N+2: PREPARA.
  - N+3 .. N+2+PULSE_LEN: `novaEntrada`=1.
- Back-to-back throughput: one request per PULSE_LEN+GAP_LEN+2 cycles.
- Timing counter: single counter sized for max(PULSE_LEN, GAP_LEN), cleared on each state entry.
- `pedido` is accepted in every FSM state; the FIFO is decoupled from the FSM.

Optional Feature:
- Macro: EMISSOR_FILTRO_DUPLICADO_EN.
- Defined: a request whose (origem,destino) pair equals any valid FIFO entry, or the pair currently held on the outputs while `ocupado`=1, is rejected and pulses `descartado`.
- Not defined: duplicates are enqueued and emitted normally.

Test Plan:
- Reset, then `pedido` (2→7) at cycle 0, PULSE_LEN=4, GAP_LEN=8 -> `origem`=2, `destino`=7 from cycle 2; `novaEntrada`=1 cycles 3..6; `ocupado` falls at cycle 15.
- Five valid requests back-to-back with DEPTH=4 while the FSM is busy (first popped immediately) -> all five emitted in order, `descartado`=0. A sixth request while `nivel`=4 and no pop that cycle -> `descartado`=1, `nivel` stays 4.
- Invalid requests (3→3) and (2→12 with MAX_ANDAR=9) -> `descartado` pulses each time; `nivel` stays 0; no emission.
- Push during the OCIOSO pop cycle with FIFO full -> `nivel` stays DEPTH, FIFO order intact (check emitted sequence).
- Reset asserted during PULSO -> next cycle `novaEntrada`=0, `origem`=0, `nivel`=0, FSM OCIOSO; queued requests are not emitted.
- With EMISSOR_FILTRO_DUPLICADO_EN: enqueue (1→5) twice while busy -> second rejected, `descartado`=1. Without the macro -> (1→5) emitted twice.
